// File: rtl/input_debouncer.sv
// input_debouncer
// Synchronizes a raw asynchronous input through an N_SYNC-stage chain, then
// accepts a new level only after it has been seen for DEBOUNCE_CYCLES
// consecutive synchronized samples. Rejected candidate changes (the input
// returned to the current output level before acceptance) are counted in a
// saturating glitch counter that software can clear.
module input_debouncer #(
    parameter int   N_SYNC          = 2,     // >= 2
    parameter int   DEBOUNCE_CYCLES = 16,    // >= 1
    parameter int   GLITCH_WIDTH    = 16,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    a_async,
    input  logic                    glitch_clr,
    output logic                    y,
    output logic                    busy,
    output logic [GLITCH_WIDTH-1:0] glitch_cnt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]        CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GLITCH_WIDTH-1:0] GLITCH_MAX = '1;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_QUALIFY = 1'b1
    } state_t;

    logic [N_SYNC-1:0]       sync_q, sync_d;
    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    y_q, y_d;
    logic                    busy_q, busy_d;
    logic [GLITCH_WIDTH-1:0] glitch_q, glitch_d;
    logic                    s;
    logic                    glitch_evt;

    // Synchronizer shift: only stage 0 ever sees the asynchronous input.
    always_comb begin
        sync_d = {sync_q[N_SYNC-2:0], a_async};
    end

    assign s = sync_q[N_SYNC-1];

    // Qualification FSM: decide next state, counter, output level and glitch event.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        y_d        = y_q;
        glitch_evt = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (s != y_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        // A single sample is already enough to accept.
                        y_d = s;
                    end else begin
                        state_d = ST_QUALIFY;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_QUALIFY: begin
                if (s != y_q) begin
                    if (cnt_q == CNT_LAST) begin
                        y_d     = s;
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    // Input fell back to the current level: reject, y untouched.
                    state_d    = ST_STABLE;
                    cnt_d      = '0;
                    glitch_evt = 1'b1;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == ST_QUALIFY);
    end

    // Saturating glitch counter; a clear and a same-cycle glitch leave a count of one.
    always_comb begin
        glitch_d = glitch_q;
        if (glitch_clr) begin
            glitch_d = glitch_evt ? GLITCH_WIDTH'(1) : '0;
        end else if (glitch_evt && (glitch_q != GLITCH_MAX)) begin
            glitch_d = glitch_q + 1'b1;
        end
    end

    // State registers with synchronous active-low reset; reset abandons any qualification.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q   <= {N_SYNC{RESET_LEVEL}};
            state_q  <= ST_STABLE;
            cnt_q    <= '0;
            y_q      <= RESET_LEVEL;
            busy_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            busy_q   <= busy_d;
            glitch_q <= glitch_d;
        end
    end

    assign y          = y_q;
    assign busy       = busy_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Testbench for input_debouncer: three parameterizations share one stimulus
// stream; a run-length reference model predicts every output each cycle.
module tb_input_debouncer;

    localparam int   NS_A = 2, DC_A = 4, GW_A = 16;
    localparam logic RL_A = 1'b0;
    localparam int   NS_B = 3, DC_B = 3, GW_B = 2;
    localparam logic RL_B = 1'b1;
    localparam int   NS_C = 2, DC_C = 1, GW_C = 4;
    localparam logic RL_C = 1'b0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_async = 1'b0;
    logic glitch_clr = 1'b0;

    logic            y_a, busy_a;
    logic [GW_A-1:0] cnt_a;
    logic            y_b, busy_b;
    logic [GW_B-1:0] cnt_b;
    logic            y_c, busy_c;
    logic [GW_C-1:0] cnt_c;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, one slot per DUT.
    int         p_ns[3] = '{NS_A, NS_B, NS_C};
    int         p_dc[3] = '{DC_A, DC_B, DC_C};
    int         p_gw[3] = '{GW_A, GW_B, GW_C};
    logic       p_rl[3] = '{RL_A, RL_B, RL_C};
    logic [7:0] m_pipe[3];
    logic       m_y[3];
    int         m_run[3];
    int         m_gcnt[3];
    int         a_high_cycles = 0;

    always #5 clk = ~clk;

    input_debouncer #(.N_SYNC(NS_A), .DEBOUNCE_CYCLES(DC_A), .GLITCH_WIDTH(GW_A), .RESET_LEVEL(RL_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .a_async(a_async), .glitch_clr(glitch_clr),
        .y(y_a), .busy(busy_a), .glitch_cnt(cnt_a));

    input_debouncer #(.N_SYNC(NS_B), .DEBOUNCE_CYCLES(DC_B), .GLITCH_WIDTH(GW_B), .RESET_LEVEL(RL_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .a_async(a_async), .glitch_clr(glitch_clr),
        .y(y_b), .busy(busy_b), .glitch_cnt(cnt_b));

    input_debouncer #(.N_SYNC(NS_C), .DEBOUNCE_CYCLES(DC_C), .GLITCH_WIDTH(GW_C), .RESET_LEVEL(RL_C)) dut_c (
        .clk(clk), .rst_n(rst_n), .a_async(a_async), .glitch_clr(glitch_clr),
        .y(y_c), .busy(busy_c), .glitch_cnt(cnt_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: s is the input delayed by N_SYNC edges; the output follows s once s
    // has disagreed with it on DC consecutive edges; a shorter disagreement that
    // ends is a glitch.
    task automatic model_step(input int i, input logic a, input logic clr, input logic rstn);
        logic s;
        logic glitch;
        int   maxv;
        if (!rstn) begin
            m_pipe[i] = {8{p_rl[i]}};
            m_y[i]    = p_rl[i];
            m_run[i]  = 0;
            m_gcnt[i] = 0;
            return;
        end
        s      = m_pipe[i][p_ns[i]-1];
        glitch = 1'b0;
        if (s != m_y[i]) begin
            m_run[i]++;
            if (m_run[i] >= p_dc[i]) begin
                m_y[i]   = s;
                m_run[i] = 0;
            end
        end else if (m_run[i] > 0) begin
            glitch   = 1'b1;
            m_run[i] = 0;
        end
        maxv = (1 << p_gw[i]) - 1;
        if (clr) m_gcnt[i] = glitch ? 1 : 0;
        else if (glitch && m_gcnt[i] < maxv) m_gcnt[i]++;
        m_pipe[i] = {m_pipe[i][6:0], a};
    endtask

    // Apply one cycle of inputs, advance the model, compare every output.
    task automatic step(input logic a, input logic clr, input logic rstn);
        a_async    = a;
        glitch_clr = clr;
        rst_n      = rstn;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i, a, clr, rstn);
        #1;
        if (y_a === 1'b1) a_high_cycles++;
        check("A.y",    32'(y_a),    32'(m_y[0]));
        check("A.busy", 32'(busy_a), 32'(m_run[0] > 0));
        check("A.cnt",  32'(cnt_a),  m_gcnt[0]);
        check("B.y",    32'(y_b),    32'(m_y[1]));
        check("B.busy", 32'(busy_b), 32'(m_run[1] > 0));
        check("B.cnt",  32'(cnt_b),  m_gcnt[1]);
        check("C.y",    32'(y_c),    32'(m_y[2]));
        check("C.busy", 32'(busy_c), 32'(m_run[2] > 0));
        check("C.cnt",  32'(cnt_c),  m_gcnt[2]);
    endtask

    // Hold a at lvl and report the edge number (1-based) at which DUT A's y reaches it.
    task automatic wait_y(input string tag, input logic lvl, input int exp_edges);
        int found;
        found = 0;
        for (int e = 1; e <= 12; e++) begin
            step(lvl, 1'b0, 1'b1);
            if (y_a === lvl) begin
                found = e;
                break;
            end
        end
        check(tag, 32'(found), 32'(exp_edges));
    endtask

    initial begin
        int   run_left;
        logic lvl;

        // Reset
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("rst.y",    32'(y_a),    32'd0);
        check("rst.busy", 32'(busy_a), 32'd0);
        check("rst.cnt",  32'(cnt_a),  32'd0);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b1);

        // Clean steps up and down
        wait_y("step.rise", 1'b1, 6);
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b1);
        wait_y("step.fall", 1'b0, 6);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b1);
        check("step.cnt", 32'(cnt_a), 32'd0);

        // Three-cycle glitch
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b1);
        check("glitch.cnt", 32'(cnt_a), 32'd1);

        // Exact-width pulse
        a_high_cycles = 0;
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b1);
        check("pulse.width", 32'(a_high_cycles), 32'd4);
        check("pulse.cnt",   32'(cnt_a),         32'd1);

        // Clear, then chatter with 10 single-cycle high runs
        step(1'b0, 1'b1, 1'b1);
        check("clr.cnt", 32'(cnt_a), 32'd0);
        for (int k = 0; k < 20; k++) step((k % 2) == 0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1);
        check("chatter.cnt", 32'(cnt_a), 32'd10);
        check("chatter.y",   32'(y_a),   32'd0);

        // Eleventh glitch with a coincident clear
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check("clrglitch.cnt", 32'(cnt_a), 32'd1);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1);

        // Reset in the middle of qualification
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b1);
        check("midq.busy_pre", 32'(busy_a), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        check("midq.y",    32'(y_a),    32'd0);
        check("midq.busy", 32'(busy_a), 32'd0);
        check("midq.cnt",  32'(cnt_a),  32'd0);
        wait_y("midq.rise", 1'b1, 6);

        // Randomized runs, clears and resets
        run_left = 0;
        lvl      = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (run_left == 0) begin
                lvl      = ~lvl;
                run_left = $urandom_range(1, 9);
            end
            run_left--;
            step(lvl, $urandom_range(0, 15) == 0, $urandom_range(0, 79) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Conditions an asynchronous, possibly bouncing digital input (pushbutton, external trigger, comparator output) into a clean, clock-synchronous level. It sits directly upstream of the positive-edge detector, which turns its output into a single-cycle pulse. The block synchronizes the input, requires the new level to hold for a programmable number of consecutive cycles before passing it on, and counts rejected glitches for diagnostics.

## Interface
- `N_SYNC`, default 2: synchronizer flip-flop stages; must be ≥2.
- `DEBOUNCE_CYCLES`, default 16: consecutive synchronized samples required to accept a new level; must be ≥1.
- `GLITCH_WIDTH`, default 16: width of the glitch counter.
- `RESET_LEVEL`, default 1'b0: value loaded into the synchronizer and `y` at reset.
- `clk` input 1: clock; the only clock.
- `rst_n` input 1: reset, synchronous and active-low.
- `a_async` input 1: raw asynchronous input.
- `glitch_clr` input 1: synchronous clear of `glitch_cnt`.
- `y` output 1: debounced level, registered.
- `busy` output 1: high while a candidate level change is being qualified.
- `glitch_cnt` output `GLITCH_WIDTH`: saturating count of rejected candidate changes.

## Operation
- Synchronizer: `N_SYNC`-stage shift chain. Its last stage is `s`. Only `s` feeds the filter.
- Qualify counter width: $clog2(DEBOUNCE_CYCLES+1).
- FSM state STABLE (`busy`=0):
  - If `s` == `y`: remain in STABLE.
  - If `s` != `y` and `DEBOUNCE_CYCLES` == 1: `y` <= `s`; remain in STABLE.
  - Otherwise: go to QUALIFY with counter <= 1.
- FSM state QUALIFY (`busy`=1):
  - If `s` != `y` and counter == `DEBOUNCE_CYCLES`-1: `y` <= `s`, go to STABLE, counter <= 0.
  - If `s` != `y` otherwise: counter++.
  - If `s` == `y` (reverted): go to STABLE, counter <= 0, count a glitch.
- Glitch counting:
  - A glitch increments `glitch_cnt` and saturates at all-ones; it never wraps.
  - `glitch_clr` sets `glitch_cnt` to 0.
  - If `glitch_clr` and a glitch occur in the same cycle, `glitch_cnt` <= 1 (the event is counted after the clear).
- `y` changes only on acceptance. It never changes in the cycle a glitch is detected.
- Reset (`rst_n`=0 at an edge), including mid-QUALIFY:
  - All synchronizer stages and `y` <= `RESET_LEVEL`.
  - State <= STABLE, counter <= 0, `busy` <= 0, `glitch_cnt` <= 0.
  - Any qualification in progress is abandoned and not counted as a glitch.
- After reset release, an input differing from `RESET_LEVEL` is qualified normally. There is no special case.

## Timing
- Reset values: `y`=`RESET_LEVEL`, `busy`=0, `glitch_cnt`=0.
- Latency: count the first edge that samples a new stable `a_async` as edge 1. `s` is valid after edge `N_SYNC`. `y` updates on edge `N_SYNC`+`DEBOUNCE_CYCLES`.
- `busy`:
  - Rises on edge `N_SYNC`+1.
  - Falls on the same edge that updates `y`, or on the edge that detects the revert.
  - For `DEBOUNCE_CYCLES`=1, `busy` never asserts.
- Minimum accepted pulse width: `DEBOUNCE_CYCLES` cycles at `s`. The output pulse then has the same width, delayed.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Metastability is tolerated only on the first synchronizer stage. No other logic reads `a_async`.

## Test plan
Parameters for all cases unless noted: `N_SYNC`=2, `DEBOUNCE_CYCLES`=4, `RESET_LEVEL`=0.
- Clean step: `a_async` 0→1, held, sampled first at edge 1 -> `y` rises at edge 6; `busy` is high over edges 3–6; `glitch_cnt` stays 0. A 1→0 step mirrors this.
- Glitch: `a_async` high for 3 cycles, then low -> `y` stays 0; `busy` high for 3 cycles; `glitch_cnt`=1.
- Exact-width pulse: `a_async` high for exactly 4 cycles -> `y` high for exactly 4 cycles, starting at edge 6; `glitch_cnt`=0.
- Chatter: `a_async` toggles every cycle for 20 cycles (10 high runs) -> `y` stays 0; `glitch_cnt`=10. Then assert `glitch_clr` coincident with an 11th revert -> `glitch_cnt`=1.
- Saturation: `GLITCH_WIDTH`=2, 5 glitches -> `glitch_cnt` reads 1, 2, 3, 3, 3.
- Reset mid-qualify: `rst_n`=0 while `busy`=1 with counter at 2 -> next cycle `y`=0, `busy`=0, `glitch_cnt`=0. With `a_async` still high after release, `y` rises 6 edges after release.
